// File: rtl/rx_desc_sched.sv
// rx_desc_sched: issues ring descriptor addresses to the receive engine
// and retires its completions strictly in order.
module rx_desc_sched #(
  parameter int IDX_W   = 4,
  parameter int MAX_OUT = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [15:0]      ring_base,
  input  logic [IDX_W-1:0] avail_tail,
  input  logic             sync_load,
  input  logic [IDX_W-1:0] sync_idx,
  output logic [31:0]      cmd_m_tdata,
  output logic             cmd_m_tvalid,
  output logic             cmd_m_tlast,
  input  logic             cmd_m_tready,
  input  logic [31:0]      stat_s_tdata,
  input  logic             stat_s_tvalid,
  input  logic             stat_s_tlast,
  output logic             stat_s_tready,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W-1:0] issue_idx,
  output logic [IDX_W:0]   outstanding,
  output logic             desc_done,
  output logic             seq_err,
  output logic             seq_err_sticky,
  output logic             idle
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMD  = 1'b1;

  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [IDX_W:0]   OUT_ONE = 1;
  localparam logic [IDX_W:0]   OUT_MAX = (IDX_W+1)'(MAX_OUT);

  logic [0:0]  state;
  logic        cmd_hs;
  logic        stat_hs;
  logic        retire;
  logic        stray;
  logic        mism;
  logic        sync_take;
  logic        start;
  logic [15:0] head_addr;
  logic [15:0] issue_addr;
  logic        unused;

  assign unused = ^{stat_s_tlast, stat_s_tdata[31:16]};

  assign cmd_m_tlast   = 1'b1;
  assign stat_s_tready = 1'b1;
  assign idle = (outstanding == '0) && !cmd_m_tvalid;

  assign head_addr  = ring_base + 16'({head_idx, 4'b0000});
  assign issue_addr = ring_base + 16'({issue_idx, 4'b0000});

  assign cmd_hs  = cmd_m_tvalid && cmd_m_tready;
  assign stat_hs = stat_s_tvalid;
  assign retire  = stat_hs && (outstanding != '0);
  assign stray   = stat_hs && (outstanding == '0);
  assign mism    = retire && (stat_s_tdata[15:0] != head_addr);

  assign sync_take = sync_load && idle && (state == S_IDLE);

  assign start = (state == S_IDLE) && !sync_take && enable &&
                 (issue_idx != avail_tail) &&
                 (outstanding < OUT_MAX);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      cmd_m_tvalid <= 1'b0;
      cmd_m_tdata  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_CMD;
            cmd_m_tvalid <= 1'b1;
            cmd_m_tdata  <= {16'h0000, issue_addr};
          end
        end
        S_CMD: begin
          if (cmd_m_tready) begin
            state        <= S_IDLE;
            cmd_m_tvalid <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          cmd_m_tvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_idx  <= '0;
      issue_idx <= '0;
    end else if (sync_take) begin
      head_idx  <= sync_idx;
      issue_idx <= sync_idx;
    end else begin
      if (retire)
        head_idx <= head_idx + IDX_ONE;
      if (cmd_hs)
        issue_idx <= issue_idx + IDX_ONE;
    end
  end

  // A cmd handshake and a retire in the same cycle cancel out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else begin
      unique case (1'b1)
        cmd_hs && !retire: outstanding <= outstanding + OUT_ONE;
        !cmd_hs && retire: outstanding <= outstanding - OUT_ONE;
        default:           outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      desc_done      <= 1'b0;
      seq_err        <= 1'b0;
      seq_err_sticky <= 1'b0;
    end else begin
      desc_done <= retire;
      seq_err   <= mism || stray;
      if (mism || stray)
        seq_err_sticky <= 1'b1;
      else if (sync_take)
        seq_err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_desc_sched.sv
// tb_rx_desc_sched: directed stimulus, cycle model of the scheduling rules
// and literal checkpoints.
module tb_rx_desc_sched;

  localparam int IDX  = 4;
  localparam int MAXO = 2;
  localparam int RING = 1 << IDX;

  logic           aclk;
  logic           aresetn;
  logic           enable;
  logic [15:0]    ring_base;
  logic [IDX-1:0] avail_tail;
  logic           sync_load;
  logic [IDX-1:0] sync_idx;
  logic [31:0]    cmd_m_tdata;
  logic           cmd_m_tvalid;
  logic           cmd_m_tlast;
  logic           cmd_m_tready;
  logic [31:0]    stat_s_tdata;
  logic           stat_s_tvalid;
  logic           stat_s_tlast;
  logic           stat_s_tready;
  logic [IDX-1:0] head_idx;
  logic [IDX-1:0] issue_idx;
  logic [IDX:0]   outstanding;
  logic           desc_done;
  logic           seq_err;
  logic           seq_err_sticky;
  logic           idle;

  rx_desc_sched #(.IDX_W(IDX), .MAX_OUT(MAXO)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .ring_base(ring_base), .avail_tail(avail_tail),
    .sync_load(sync_load), .sync_idx(sync_idx),
    .cmd_m_tdata(cmd_m_tdata), .cmd_m_tvalid(cmd_m_tvalid),
    .cmd_m_tlast(cmd_m_tlast), .cmd_m_tready(cmd_m_tready),
    .stat_s_tdata(stat_s_tdata), .stat_s_tvalid(stat_s_tvalid),
    .stat_s_tlast(stat_s_tlast), .stat_s_tready(stat_s_tready),
    .head_idx(head_idx), .issue_idx(issue_idx),
    .outstanding(outstanding), .desc_done(desc_done),
    .seq_err(seq_err), .seq_err_sticky(seq_err_sticky), .idle(idle)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: indices mod RING, addresses mod 64K.
  int m_head, m_issue, m_out, m_valid, m_data;
  int m_done, m_err, m_sticky;

  function automatic int addr_of(input int base, input int i);
    return (base + 16 * i) % 65536;
  endfunction

  task automatic model_reset();
    m_head = 0; m_issue = 0; m_out = 0; m_valid = 0; m_data = 0;
    m_done = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic model_step();
    int base, nh, ni, nv, ret, hs;
    base = int'(ring_base);
    nh = m_head; ni = m_issue; nv = m_valid;
    ret = 0;
    hs = (m_valid != 0 && cmd_m_tready) ? 1 : 0;
    m_done = 0; m_err = 0;
    if (stat_s_tvalid) begin
      if (m_out > 0) begin
        ret = 1; m_done = 1;
        if (int'(stat_s_tdata[15:0]) != addr_of(base, m_head)) m_err = 1;
        nh = (m_head + 1) % RING;
      end else m_err = 1;
    end
    if (m_valid != 0) begin
      if (cmd_m_tready) begin
        ni = (m_issue + 1) % RING; nv = 0;
      end
    end else if (sync_load && m_out == 0) begin
      nh = int'(sync_idx); ni = int'(sync_idx); m_sticky = 0;
    end else if (enable && m_issue != int'(avail_tail) && m_out < MAXO) begin
      nv = 1; m_data = addr_of(base, m_issue);
    end
    m_out = m_out + hs - ret;
    if (m_err != 0) m_sticky = 1;
    m_head = nh; m_issue = ni; m_valid = nv;
  endtask

  initial model_reset();

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) model_reset();
    else model_step();
    #1;
    chk("tvalid", 32'(cmd_m_tvalid), m_valid);
    if (m_valid != 0) chk("tdata", cmd_m_tdata, m_data);
    chk("tlast", 32'(cmd_m_tlast), 1);
    chk("stat_tready", 32'(stat_s_tready), 1);
    chk("head_idx", 32'(head_idx), m_head);
    chk("issue_idx", 32'(issue_idx), m_issue);
    chk("outstanding", 32'(outstanding), m_out);
    chk("desc_done", 32'(desc_done), m_done);
    chk("seq_err", 32'(seq_err), m_err);
    chk("sticky", 32'(seq_err_sticky), m_sticky);
    chk("idle", 32'(idle), (m_out == 0 && m_valid == 0) ? 1 : 0);
    if (aresetn && desc_done === 1'b1) n_done++;
    if (aresetn && seq_err === 1'b1) n_err++;
  end

  // Engine emulation: echoes each accepted command address 4 cycles later.
  bit hold_ready = 0;
  bit withhold = 0;
  bit corrupt_next = 0;
  int q_cnt[$];
  logic [15:0] q_addr[$];
  logic [15:0] cap[$];

  task automatic tick();
    @(negedge aclk);
    stat_s_tvalid = 1'b0;
    stat_s_tdata = '0;
    foreach (q_cnt[i]) q_cnt[i]--;
    if (q_cnt.size() > 0 && q_cnt[0] <= 0 && !withhold) begin
      stat_s_tvalid = 1'b1;
      stat_s_tdata = {16'h0000, q_addr[0]};
      void'(q_cnt.pop_front());
      void'(q_addr.pop_front());
    end
    cmd_m_tready = !hold_ready;
    if (cmd_m_tvalid && cmd_m_tready) begin
      cap.push_back(cmd_m_tdata[15:0]);
      q_cnt.push_back(4);
      q_addr.push_back(corrupt_next ? cmd_m_tdata[15:0] + 16'h0030
                                    : cmd_m_tdata[15:0]);
      corrupt_next = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    aresetn = 1'b0; enable = 1'b0; ring_base = 16'h0100;
    avail_tail = '0; sync_load = 1'b0; sync_idx = '0;
    cmd_m_tready = 1'b1; stat_s_tvalid = 1'b0; stat_s_tdata = '0;
    stat_s_tlast = 1'b0;
    #2;
    chk("rst_tdata", cmd_m_tdata, 0);
    chk("rst_tvalid", 32'(cmd_m_tvalid), 0);
    chk("rst_idle", 32'(idle), 1);
    ticks(3);
    aresetn = 1'b1;

    // Basic issue/retire of three descriptors.
    enable = 1'b1; avail_tail = 3;
    ticks(30);
    chk("t1_n", cap.size(), 3);
    chk("t1_a0", 32'(cap[0]), 32'h0100);
    chk("t1_a1", 32'(cap[1]), 32'h0110);
    chk("t1_a2", 32'(cap[2]), 32'h0120);
    chk("t1_done", n_done, 3);
    chk("t1_head", 32'(head_idx), 3);
    chk("t1_issue", 32'(issue_idx), 3);
    chk("t1_idle", 32'(idle), 1);

    // Wrap around the ring end after a sync to index 14.
    enable = 1'b0; sync_load = 1'b1; sync_idx = 14;
    tick();
    sync_load = 1'b0; avail_tail = 2; enable = 1'b1;
    cap.delete();
    ticks(40);
    chk("t2_n", cap.size(), 4);
    chk("t2_a0", 32'(cap[0]), 32'h01E0);
    chk("t2_a1", 32'(cap[1]), 32'h01F0);
    chk("t2_a2", 32'(cap[2]), 32'h0100);
    chk("t2_a3", 32'(cap[3]), 32'h0110);
    chk("t2_head", 32'(head_idx), 2);
    chk("t2_issue", 32'(issue_idx), 2);

    // Backpressure: command held stable.
    hold_ready = 1; avail_tail = 3;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_valid", 32'(cmd_m_tvalid), 1);
      chk("t3_data", cmd_m_tdata, 32'h0120);
      chk("t3_issue", 32'(issue_idx), 2);
    end
    hold_ready = 0;
    ticks(10);
    chk("t3_issue_end", 32'(issue_idx), 3);
    chk("t3_head_end", 32'(head_idx), 3);

    // Outstanding limit with completions withheld.
    cap.delete();
    withhold = 1; avail_tail = 6;
    ticks(15);
    chk("t4_out", 32'(outstanding), 2);
    chk("t4_issue", 32'(issue_idx), 5);
    chk("t4_valid", 32'(cmd_m_tvalid), 0);
    chk("t4_n", cap.size(), 2);
    withhold = 0;
    ticks(20);
    chk("t4_n2", cap.size(), 3);
    chk("t4_a2", 32'(cap[2]), 32'h0150);
    chk("t4_head", 32'(head_idx), 6);

    // Wrong completion address, then sync clears sticky.
    corrupt_next = 1; avail_tail = 7;
    ticks(12);
    chk("t5_sticky", 32'(seq_err_sticky), 1);
    chk("t5_head", 32'(head_idx), 7);
    chk("t5_nerr", n_err, 1);
    sync_load = 1'b1; sync_idx = 7;
    tick();
    sync_load = 1'b0;
    tick();
    chk("t5_clr", 32'(seq_err_sticky), 0);
    chk("t5_issue", 32'(issue_idx), 7);

    // Completion with nothing outstanding.
    enable = 1'b0; d0 = n_done;
    q_cnt.push_back(0); q_addr.push_back(16'h0170);
    ticks(3);
    chk("t6_nerr", n_err, 2);
    chk("t6_done", n_done, d0);
    chk("t6_head", 32'(head_idx), 7);
    chk("t6_sticky", 32'(seq_err_sticky), 1);

    // Reset while a command is held.
    enable = 1'b1; avail_tail = 8; hold_ready = 1;
    ticks(2);
    chk("t7_valid", 32'(cmd_m_tvalid), 1);
    #3 aresetn = 1'b0;
    #1;
    chk("t7_rvalid", 32'(cmd_m_tvalid), 0);
    chk("t7_rdata", cmd_m_tdata, 0);
    chk("t7_rhead", 32'(head_idx), 0);
    chk("t7_rissue", 32'(issue_idx), 0);
    chk("t7_rout", 32'(outstanding), 0);
    chk("t7_rsticky", 32'(seq_err_sticky), 0);
    chk("t7_ridle", 32'(idle), 1);
    q_cnt.delete(); q_addr.delete(); cap.delete();
    enable = 1'b0; avail_tail = 0; hold_ready = 0;
    tick();
    aresetn = 1'b1;
    ticks(5);
    enable = 1'b1;
    ticks(3);
    chk("t7_quiet", cap.size(), 0);
    avail_tail = 1;
    ticks(10);
    chk("t7_n", cap.size(), 1);
    chk("t7_a0", 32'(cap[0]), 32'h0100);
    chk("t7_head", 32'(head_idx), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
